hvac_zone_scheduler: RTL and testbench
======================================

// Module: hvac_zone_scheduler
// PURPOSE
//  Shares one heating/cooling plant between NZONES rooms, each with a 5-bit temperature sensor.
//  Per-zone demand uses the same hysteresis as the single-room AC controller:
//    heat request at <=18, cool request at >=22, release at target 20.
//  A round-robin arbiter picks one zone at a time and drives the plant's heat/cool enables and damper select.
//  It enforces minimum-on, maximum-on (timeslice) and changeover dead time to protect the plant.
// PARAMETERS
//  NZONES     4   number of zones (2..8)
//  ZW         2   zone index width, clog2(NZONES)
//  T_HEAT_ON  18  zone requests heat when temp <= this value
//  T_COOL_ON  22  zone requests cool when temp >= this value; T_HEAT_ON < T_TARGET < T_COOL_ON
//  T_TARGET   20  heating releases at temp >= this value; cooling releases at temp <= this value
//  MIN_ON     8   minimum cycles heating/cooling stays asserted once granted
//  MAX_ON     32  timeslice: after this many cycles, release if another zone requests
//  DEAD       2   cycles with plant off between any release and the next grant
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  temperature  in   5*NZONES   packed zone temps, zone i = [5*i+4:5*i], unsigned
//  zone_en      in   NZONES     per-zone enable; a disabled zone never requests
//  heating      out  1          plant heat enable
//  cooling      out  1          plant cool enable
//  zone_sel     out  ZW         damper select: zone currently served
//  active       out  1          high while in HEAT or COOL
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; heating=0, cooling=0, zone_sel=0, active=0.
//   - rr_ptr=0; dwell=0; dead counter=0.
//   - Reset asserted mid-HEAT/COOL drops all outputs at the next edge; no dead time is applied.
//  Requests (combinational from current inputs):
//   - heat_req[i] = zone_en[i] & temp_i<=T_HEAT_ON
//   - cool_req[i] = zone_en[i] & temp_i>=T_COOL_ON
//   - Temps 19..21 raise no request.
//  All outputs are registered.
//  FSM states: IDLE, HEAT, COOL, DEAD.
//   IDLE:
//    - If any request, grant the first requesting zone searching upward from rr_ptr, wrapping NZONES-1 -> 0.
//    - Enter HEAT if that zone has heat_req, else COOL.
//    - Set zone_sel=grant and rr_ptr=(grant+1) mod NZONES; dwell=0.
//    - Latency: request sampled at edge k -> heating/cooling=1 after edge k.
//   HEAT/COOL:
//    - dwell increments each cycle and saturates at MAX_ON.
//    - zone_en[zone_sel]=0 releases at the next edge, overriding MIN_ON.
//    - Otherwise release needs dwell>=MIN_ON-1 (output high exactly >=MIN_ON cycles) plus one of:
//      (a) HEAT: temp>=T_TARGET; COOL: temp<=T_TARGET
//      (b) dwell>=MAX_ON-1 and any other zone requests
//    - If neither (a) nor (b) holds, the grant is held indefinitely.
//   Release: heating=cooling=active=0 at that edge, go to DEAD, zone_sel holds its value.
//   DEAD:
//    - Stays exactly DEAD cycles, then enters IDLE.
//    - IDLE needs one more edge to grant, so plant-off time is DEAD+1 cycles.
//  Invariants:
//   - heating & cooling never both 1; active == heating|cooling.
//   - zone_sel is stable whenever active=1.
//  Simultaneous requests: round-robin only, no heat/cool priority. A zone served last is lowest priority next.
//  Temperature outside 0..31 cannot occur (5-bit). Thresholds compare unsigned.
// TESTING
//  1 Reset, zone0 temp=15, others 20, all enabled
//    -> heating=1, zone_sel=0 one cycle after rst falls.
//    Raise temp0 to 20 at dwell 3 -> heating held until 8 cycles total, then 0; next grant >=3 cycles later.
//  2 Zone1 temp=25 only
//    -> cooling=1, zone_sel=1. Temp1=21 keeps cooling; temp1=20 releases (after MIN_ON). heating stays 0 throughout.
//  3 Zones 0,2 temp=10 and held there
//    -> zone0 served 32 cycles, release, DEAD, then zone2 served 32 cycles, then zone0 again.
//  4 Zone3 heating at dwell 2, zone_en[3] cleared
//    -> heating=0 at next edge despite MIN_ON; zone3 not re-granted while disabled.
//  5 rst pulsed high for 1 cycle while cooling zone2
//    -> all outputs 0 next edge, rr_ptr=0.
//    With zones 1,2 requesting after reset -> zone1 granted first.
//  6 Every cycle check heating&cooling==0 and active==(heating|cooling); any violation flags ***TEST FAILED***.

Source files
------------

// File: rtl/hvac_zone_scheduler.sv
// ============================================================================
// hvac_zone_scheduler
//   Round-robin sharing of one heat/cool plant between NZONES rooms, with
//   minimum-on, timeslice and changeover dead-time protection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hvac_zone_scheduler #(
  parameter int NZONES    = 4,
  parameter int ZW        = 2,
  parameter int T_HEAT_ON = 18,
  parameter int T_COOL_ON = 22,
  parameter int T_TARGET  = 20,
  parameter int MIN_ON    = 8,
  parameter int MAX_ON    = 32,
  parameter int DEAD      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*NZONES-1:0]   temperature,
  input  logic [NZONES-1:0]     zone_en,
  output logic                  heating,
  output logic                  cooling,
  output logic [ZW-1:0]         zone_sel,
  output logic                  active
);

  localparam int DW  = $clog2(MAX_ON + 1);
  localparam int DCW = $clog2(DEAD + 1);

  localparam logic [4:0]     C_HEAT_ON = 5'(T_HEAT_ON);
  localparam logic [4:0]     C_COOL_ON = 5'(T_COOL_ON);
  localparam logic [4:0]     C_TARGET  = 5'(T_TARGET);
  localparam logic [DW-1:0]  C_MIN_M1  = DW'(MIN_ON - 1);
  localparam logic [DW-1:0]  C_MAX_M1  = DW'(MAX_ON - 1);
  localparam logic [DW-1:0]  C_MAX     = DW'(MAX_ON);
  localparam logic [DCW-1:0] C_DEAD_M1 = DCW'(DEAD - 1);
  localparam logic [ZW-1:0]  C_LAST    = ZW'(NZONES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAT = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [DCW-1:0]    dead_q, dead_d;
  logic [ZW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ZW-1:0]     zone_sel_q, zone_sel_d;
  logic              heating_q, cooling_q, active_q;

  logic [4:0]        zone_temp [NZONES];
  logic [NZONES-1:0] heat_req, cool_req, any_req;

  for (genvar i = 0; i < NZONES; i++) begin : g_zone
    assign zone_temp[i] = temperature[5*i +: 5];
    assign heat_req[i]  = zone_en[i] & (zone_temp[i] <= C_HEAT_ON);
    assign cool_req[i]  = zone_en[i] & (zone_temp[i] >= C_COOL_ON);
  end
  assign any_req = heat_req | cool_req;

  // First requesting zone at or above rr_ptr, wrapping to zone 0.
  logic          grant_found;
  logic [ZW-1:0] grant_idx;
  logic [ZW-1:0] cand;
  int            j;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    j           = 0;
    for (int k = 0; k < NZONES; k++) begin
      j    = (int'(rr_ptr_q) + k) % NZONES;
      cand = ZW'(j);
      if (!grant_found && any_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  logic [4:0]        sel_temp;
  logic [NZONES-1:0] sel_mask;
  logic              at_target, other_req, release_w;
  always_comb begin
    sel_temp  = zone_temp[zone_sel_q];
    sel_mask  = NZONES'(1) << zone_sel_q;
    other_req = |(any_req & ~sel_mask);
    at_target = (state_q == S_HEAT) ? (sel_temp >= C_TARGET) : (sel_temp <= C_TARGET);
    // A disabled zone drops immediately, ignoring the minimum-on guard.
    release_w = !zone_en[zone_sel_q] ||
                ((dwell_q >= C_MIN_M1) && (at_target || ((dwell_q >= C_MAX_M1) && other_req)));
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    dead_d     = dead_q;
    rr_ptr_d   = rr_ptr_q;
    zone_sel_d = zone_sel_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d    = heat_req[grant_idx] ? S_HEAT : S_COOL;
          zone_sel_d = grant_idx;
          rr_ptr_d   = (grant_idx == C_LAST) ? '0 : grant_idx + 1'b1;
          dwell_d    = '0;
        end
      end
      S_HEAT, S_COOL: begin
        if (dwell_q != C_MAX) dwell_d = dwell_q + 1'b1;
        if (release_w) begin
          state_d = S_DEAD;
          dead_d  = '0;
        end
      end
      S_DEAD: begin
        if (dead_q == C_DEAD_M1) state_d = S_IDLE;
        else                     dead_d  = dead_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dwell_q    <= '0;
      dead_q     <= '0;
      rr_ptr_q   <= '0;
      zone_sel_q <= '0;
      heating_q  <= 1'b0;
      cooling_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      dead_q     <= dead_d;
      rr_ptr_q   <= rr_ptr_d;
      zone_sel_q <= zone_sel_d;
      heating_q  <= (state_d == S_HEAT);
      cooling_q  <= (state_d == S_COOL);
      active_q   <= (state_d == S_HEAT) || (state_d == S_COOL);
    end
  end

  assign heating  = heating_q;
  assign cooling  = cooling_q;
  assign zone_sel = zone_sel_q;
  assign active   = active_q;

endmodule

`default_nettype wire

// File: tb/tb_hvac_zone_scheduler.sv
// ============================================================================
// tb_hvac_zone_scheduler
//   Scenario bench for the zone scheduler with an expected-grant queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hvac_zone_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] temperature;
  logic [3:0]  zone_en;
  logic        heating, cooling, active;
  logic [1:0]  zone_sel;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int zone;
    bit heat;
    int len;
    int gap;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  hvac_zone_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .temperature(temperature),
    .zone_en    (zone_en),
    .heating    (heating),
    .cooling    (cooling),
    .zone_sel   (zone_sel),
    .active     (active)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ((heating & cooling) !== 1'b0 || active !== (heating | cooling)) begin
        bad++;
        $display("FAIL invariant heat=%b cool=%b active=%b ***TEST FAILED***", heating, cooling, active);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_temp(input int z, input int t);
    temperature[5*z +: 5] = 5'(t);
  endtask

  // Measures one grant: off samples before it, zone/mode, and on length.
  task automatic run_grant(input int budget, output int zone, output bit h, output bit c,
                           output int len, output int gap, output bit to, output bit moved);
    to = 0; moved = 0; gap = 0; len = 0; zone = 0; h = 0; c = 0;
    while (active !== 1'b1) begin
      gap++;
      if (gap > budget) begin to = 1; return; end
      cyc();
    end
    zone = int'(zone_sel); h = heating; c = cooling;
    while (active === 1'b1) begin
      len++;
      if (int'(zone_sel) != zone) moved = 1;
      if (len > budget) begin to = 1; return; end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    temperature = '0;
    for (int z = 0; z < 4; z++) set_temp(z, 20);
    set_temp(0, 15);
    zone_en = 4'hF;
    mon_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      total++;
      if ({heating, cooling, active, zone_sel} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs got h=%b c=%b a=%b sel=%0d want all 0", heating, cooling, active, zone_sel);
      end
    end
    rst = 1'b0;
    cyc();
    total++;
    if (heating !== 1'b1 || cooling !== 1'b0 || zone_sel !== 2'd0) begin
      bad++;
      $display("FAIL first_grant got h=%b c=%b sel=%0d want h=1 c=0 sel=0", heating, cooling, zone_sel);
    end
  endtask

  // Continues the zone0 heat grant: target reached at dwell 3 must still hold 8 cycles.
  task automatic test_min_on();
    int len = 1;
    int gap;
    for (int n = 0; n < 3; n++) begin
      cyc();
      if (heating === 1'b1) len++;
    end
    set_temp(0, 20);
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (heating === 1'b1) len++;
      else break;
    end
    total++;
    if (len != 8) begin
      bad++;
      $display("FAIL min_on_len got %0d want 8", len);
    end
    set_temp(1, 25);
    gap = 1;
    while (active !== 1'b1 && gap < 50) begin
      cyc();
      if (active !== 1'b1) gap++;
    end
    total++;
    if (gap != 3) begin
      bad++;
      $display("FAIL dead_gap got %0d want 3", gap);
    end
  endtask

  task automatic test_cool();
    int held = 0;
    total++;
    if (cooling !== 1'b1 || heating !== 1'b0 || zone_sel !== 2'd1) begin
      bad++;
      $display("FAIL cool_grant got h=%b c=%b sel=%0d want h=0 c=1 sel=1", heating, cooling, zone_sel);
    end
    set_temp(1, 21);
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (cooling === 1'b1 && heating === 1'b0) held++;
    end
    total++;
    if (held != 40) begin
      bad++;
      $display("FAIL cool_hold_21 got %0d want 40", held);
    end
    set_temp(1, 20);
    cyc();
    total++;
    if (cooling !== 1'b0 || heating !== 1'b0) begin
      bad++;
      $display("FAIL cool_release got c=%b h=%b want 0 0", cooling, heating);
    end
    repeat (5) cyc();
  endtask

  task automatic test_timeslice();
    int zone, len, gap;
    bit h, c, to, moved;
    exp_t e;
    rst = 1'b1;
    for (int z = 0; z < 4; z++) set_temp(z, 20);
    set_temp(0, 10);
    set_temp(2, 10);
    cyc(); cyc();
    rst = 1'b0;
    sbq.push_back('{zone: 0, heat: 1, len: 32, gap: 1});
    sbq.push_back('{zone: 2, heat: 1, len: 32, gap: 3});
    sbq.push_back('{zone: 0, heat: 1, len: 32, gap: 3});
    while (sbq.size() > 0) begin
      run_grant(200, zone, h, c, len, gap, to, moved);
      e = sbq.pop_front();
      total++;
      if (to || moved || zone != e.zone || h != e.heat || c == e.heat || len != e.len || gap != e.gap) begin
        bad++;
        $display("FAIL timeslice got zone=%0d h=%b c=%b len=%0d gap=%0d to=%b moved=%b want zone=%0d h=%b len=%0d gap=%0d",
                 zone, h, c, len, gap, to, moved, e.zone, e.heat, e.len, e.gap);
      end
    end
    set_temp(0, 20);
    set_temp(2, 20);
    repeat (5) cyc();
  endtask

  task automatic test_disable();
    int n = 0;
    int seen = 0;
    set_temp(3, 10);
    while (active !== 1'b1 && n < 50) begin cyc(); n++; end
    total++;
    if (active !== 1'b1 || zone_sel !== 2'd3 || heating !== 1'b1) begin
      bad++;
      $display("FAIL z3_grant got a=%b sel=%0d h=%b want 1 3 1", active, zone_sel, heating);
    end
    cyc(); cyc();
    zone_en[3] = 1'b0;
    cyc();
    total++;
    if (heating !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL disable_release got h=%b a=%b want 0 0", heating, active);
    end
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (active === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL disabled_regrant got %0d active cycles want 0", seen);
    end
    zone_en[3] = 1'b1;
    n = 0;
    while (active !== 1'b1 && n < 50) begin cyc(); n++; end
    total++;
    if (active !== 1'b1 || zone_sel !== 2'd3) begin
      bad++;
      $display("FAIL reenable_grant got a=%b sel=%0d want 1 3", active, zone_sel);
    end
    set_temp(3, 20);
    n = 0;
    while (active !== 1'b0 && n < 50) begin cyc(); n++; end
  endtask

  task automatic test_reset_mid_cool();
    int n = 0;
    set_temp(2, 25);
    while (!(active === 1'b1 && zone_sel === 2'd2) && n < 50) begin cyc(); n++; end
    total++;
    if (cooling !== 1'b1 || zone_sel !== 2'd2) begin
      bad++;
      $display("FAIL z2_cool got c=%b sel=%0d want 1 2", cooling, zone_sel);
    end
    cyc(); cyc();
    rst = 1'b1;
    set_temp(1, 25);
    cyc();
    total++;
    if ({heating, cooling, active, zone_sel} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset got h=%b c=%b a=%b sel=%0d want all 0", heating, cooling, active, zone_sel);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (cooling !== 1'b1 || zone_sel !== 2'd1) begin
      bad++;
      $display("FAIL post_reset_grant got c=%b sel=%0d want 1 1", cooling, zone_sel);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int gap = 0;
    set_temp(1, 20);
    while (active !== 1'b0 && n < 50) begin cyc(); n++; end
    while (active !== 1'b1 && gap < 50) begin gap++; cyc(); end
    total++;
    if (gap != 3 || zone_sel !== 2'd2 || cooling !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back got gap=%0d sel=%0d c=%b want 3 2 1", gap, zone_sel, cooling);
    end
    set_temp(2, 20);
    repeat (15) cyc();
  endtask

  initial begin
    test_reset();
    test_min_on();
    test_cool();
    test_timeslice();
    test_disable();
    test_reset_mid_cool();
    test_back_to_back();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
